// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank debug readback unit:
// FSM state encoding and default bank geometry.
package reg_bank_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_REGS = 8;
    localparam int DEFAULT_WIDTH    = 16;

endpackage : reg_bank_reader_pkg

// File: rtl/reg_bank_reader_word_select.sv
// Combinational NUM_REGS:1 word mux selecting one snapshot word by index.
module reg_word_select #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*WIDTH-1:0] words_flat,
    input  logic [IDX_W-1:0]          sel,
    output logic [WIDTH-1:0]          word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == IDX_W'(i)) begin
                word = words_flat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule : reg_word_select

// File: rtl/reg_bank_reader.sv
// Snapshots the whole register bank on start, then streams the frozen words
// out lowest index first over valid/ready, pulsing done after the last beat.
module reg_bank_reader
    import reg_bank_reader_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 snap_load;
    logic [NUM_REGS*WIDTH-1:0] snap_flat;
    logic [WIDTH-1:0]     sel_word;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // out_valid is implied by being in STREAM, so ready alone completes a beat
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // One load-enabled word register per bank entry; all capture on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_snap
            logic [WIDTH-1:0] word_d, word_q;

            always_comb begin
                word_d = word_q;
                if (snap_load) begin
                    word_d = regs_flat[gi*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign snap_flat[gi*WIDTH +: WIDTH] = word_q;
        end
    endgenerate

    reg_word_select #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_word_select (
        .words_flat (snap_flat),
        .sel        (idx_q),
        .word       (sel_word)
    );

    // Outputs decode registered state only; data is forced to zero outside a stream.
    always_comb begin
        out_valid = (state_q == ST_STREAM);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        out_index = idx_q;
        out_last  = out_valid && (idx_q == LAST_IDX);
        out_data  = out_valid ? sel_word : '0;
    end

endmodule : reg_bank_reader

// File: tb/tb_reg_bank_reader.sv
// Randomized scoreboard bench for reg_bank_reader: stimulus pushes expected
// words when a start is accepted, a negedge monitor pops and compares beats.
module tb_reg_bank_reader;

    localparam int N = 8;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N*W-1:0] regs_flat;
    logic           busy, out_valid, out_ready, out_last, done;
    logic [W-1:0]   out_data;
    logic [2:0]     out_index;

    logic [W-1:0]   regs [N];
    exp_t           q [$];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  pending_last = 0;
    bit  exp_done_r = 0;
    bit  done_seen = 0;
    int  done_cyc = 0;
    int  start_cyc = 0;
    int  ready_mode = 0;
    int  stall_cnt = 0;
    bit  acc;

    reg_bank_reader #(.NUM_REGS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .regs_flat (regs_flat),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < N; i++) regs_flat[i*W +: W] = regs[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Consumer: drives out_ready shortly after each edge according to the active policy.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (out_valid && out_index == 3'd2 && stall_cnt < 3) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every beat is compared against the front of the scoreboard.
    always @(negedge clk) begin
        bit have;
        exp_done_r   = pending_last;
        pending_last = 0;
        have = (q.size() > 0);
        chk("done", done, exp_done_r);
        chk("busy", busy, have || exp_done_r);
        chk("out_valid", out_valid, have);
        if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        if (have) begin
            chk("out_data", out_data, q[0].data);
            chk("out_index", out_index, q[0].idx);
            chk("out_last", out_last, q[0].last);
            $display("beat idx=%0d data=%04h ready=%0b last=%0b", out_index, out_data, out_ready, out_last);
            if (out_ready) begin
                pending_last = q[0].last;
                void'(q.pop_front());
            end
        end else begin
            chk("idle_index", out_index, 0);
            chk("idle_last", out_last, 0);
        end
    end

    // Raises start so it is sampled at the next edge; the reference model
    // accepts it only when no words are outstanding and no done is due.
    task automatic issue_start(output bit accepted);
        start = 1'b1;
        @(posedge clk);
        accepted = (q.size() == 0) && !pending_last && !exp_done_r;
        if (accepted) begin
            for (int i = 0; i < N; i++) q.push_back('{regs[i], 3'(i), (i == N - 1)});
        end
        #1;
        start_cyc = cyc;
        start = 1'b0;
        $display("start accepted=%0b at cycle %0d", accepted, start_cyc);
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (done_seen) begin
                seen = 1;
                break;
            end
        end
        chk("done_within_bound", seen, 1);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < N; i++) regs[i] = W'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) regs[i] = W'(16'h1000 + i);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Basic stream with ready tied high
        repeat (3) @(posedge clk);
        #1;
        done_seen = 0;
        issue_start(acc);
        wait_done(50);
        chk("latency_basic", done_cyc - start_cyc, N);
        repeat (3) @(negedge clk);

        // Backpressure: three stalled cycles on index 2
        randomize_regs();
        ready_mode = 2;
        stall_cnt  = 0;
        done_seen  = 0;
        issue_start(acc);
        wait_done(50);
        chk("latency_stall", done_cyc - start_cyc, N + 3);
        chk("stall_count", stall_cnt, 3);
        ready_mode = 0;
        repeat (3) @(negedge clk);

        // Snapshot isolation: bank overwritten right after capture
        randomize_regs();
        ready_mode = 1;
        done_seen  = 0;
        issue_start(acc);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) regs[i] = 16'hFFFF;
        wait_done(200);
        ready_mode = 0;
        repeat (3) @(negedge clk);

        // Starts during STREAM and DONE are ignored; the one after DONE is taken
        randomize_regs();
        done_seen = 0;
        issue_start(acc);
        repeat (2) @(negedge clk);
        issue_start(acc);
        chk("start_in_stream_ignored", acc, 0);
        wait_done(50);
        issue_start(acc);
        chk("start_in_done_ignored", acc, 0);
        randomize_regs();
        done_seen = 0;
        issue_start(acc);
        chk("start_after_done_taken", acc, 1);
        wait_done(50);
        repeat (3) @(negedge clk);

        // Async reset while index 4 is presented
        randomize_regs();
        done_seen = 0;
        issue_start(acc);
        begin
            bit found = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_valid && out_index == 3'd4) begin
                    found = 1;
                    break;
                end
            end
            chk("reached_index4", found, 1);
        end
        #2 reset = 1'b1;
        q.delete();
        pending_last = 0;
        exp_done_r   = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", done_seen, 0);
        randomize_regs();
        issue_start(acc);
        wait_done(50);
        repeat (2) @(negedge clk);

        // Ready without valid in IDLE
        ready_mode = 0;
        repeat (10) @(negedge clk);

        // Random streams with random backpressure
        for (int s = 0; s < 4; s++) begin
            randomize_regs();
            ready_mode = 1;
            done_seen  = 0;
            issue_start(acc);
            wait_done(200);
            repeat ($urandom_range(2, 4)) @(negedge clk);
        end
        ready_mode = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_bank_reader
